vc_vr_mc_converter: RTL
=======================

Name: vc_vr_mc_converter

Overview:
Multi-channel successor of the single-channel valid/credit to valid/ready converter.
- Upstream: a valid/credit link carrying CH_NUM virtual channels, each with CREDIT_NUM buffer slots.
- Downstream: a single valid/ready stream.
- Each channel has its own buffer and credit return. Channels with data are served round-robin, so one stalled channel cannot starve the others of credits.

Parameters:
DATA_WIDTH, 8, payload width in bits
CREDIT_NUM, 4, buffer depth per channel (credits per channel); must be >= 1
CH_NUM, 2, number of virtual channels; must be >= 2
CH_WIDTH, $clog2(CH_NUM), channel index width (derived, localparam)
CNT_WIDTH, $clog2(CREDIT_NUM+1), occupancy and pending-credit counter width (derived, localparam)

Ports:
clk  input  1  clock; all logic on its rising edge
rst_n  input  1  reset, asynchronous, active-low
s_data_i  input  DATA_WIDTH  upstream payload
s_valid_i  input  1  upstream beat valid; one beat per cycle max
s_ch_i  input  CH_WIDTH  channel of the upstream beat
s_credit_o  output  CH_NUM  per-channel credit return; each cycle high returns one credit on that channel
m_data_o  output  DATA_WIDTH  downstream payload
m_ch_o  output  CH_WIDTH  channel of the downstream beat
m_valid_o  output  1  downstream valid
m_ready_i  input  1  downstream ready

Behaviour:
- Reset values:
  - s_credit_o = 0; m_valid_o = 0; m_data_o = 0; m_ch_o = 0.
  - All buffers empty; RR pointer = 0.
  - Per-channel pending-credit counter = CREDIT_NUM.
- Initial credits: after rst_n deasserts, each s_credit_o[c] is high for exactly CREDIT_NUM consecutive cycles (all channels in parallel), then low. This is the initial credit grant.
- Credit return:
  - s_credit_o[c] is registered and equals (pending[c] != 0).
  - pending[c] increments on each pop of channel c and decrements on each cycle s_credit_o[c] is high. Both may happen in the same cycle (net 0).
  - A pop produces a credit pulse starting the cycle after the pop edge.
- Write: a beat is accepted when s_valid_i = 1 at a rising edge, s_ch_i < CH_NUM, and occ[s_ch_i] < CREDIT_NUM (evaluated before this edge's pop). Accepted data goes to the tail of that channel's FIFO.
- Overflow or illegal channel: the beat is dropped, with no state change and no credit. This is a protocol violation by the sender.
- Output:
  - m_valid_o = OR of non-empty channels, computed from registered state.
  - m_data_o and m_ch_o come from the head of the granted channel.
  - Latency: a beat written at edge N is visible on m_* after edge N (one cycle) if its channel is granted.
- Grant:
  - Combinational round-robin: the first non-empty channel at or after the RR pointer.
  - The grant is locked while m_valid_o && !m_ready_i, so m_data_o and m_ch_o stay stable until the handshake.
- Pop on m_valid_o && m_ready_i: the head of the granted channel is removed, and the RR pointer becomes (granted+1) mod CH_NUM.
- Simultaneous write and pop on the same channel:
  - Both happen; occupancy is unchanged.
  - A write to a full channel is still rejected even if that channel pops in the same cycle.
- Each FIFO uses wrap-around read/write pointers modulo CREDIT_NUM, so non-power-of-2 depths must work.
- Reset mid-operation: all state clears immediately (asynchronously). The initial credit grant repeats after release.

Optional Feature:
VC_VR_MC_ERR_EN
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - err_o is sticky, set the cycle after a dropped beat (overflow or illegal channel), cleared only by reset.
  - Adds a simulation assertion that fires on the drop.
- Undefined: no err_o port; drops are silent.

Decomposition:
- Package vc_vr_mc_pkg: ch_idx_t typedef, the CH_WIDTH/CNT_WIDTH helper functions, and the credit-counter reset constant.
- Sub-module vc_vr_ch_fifo: one channel's FIFO, occupancy counter, and pending-credit counter/credit output. Instantiated CH_NUM times via generate.
- Top level: write demux, round-robin arbiter with lock, output mux, optional error flag.

Test Plan:
- Reset release, default params: s_credit_o = 2'b11 for exactly 4 cycles, then 2'b00; m_valid_o = 0 throughout.
- Write 0xAA on ch0, m_ready_i = 0: m_valid_o = 1, m_data_o = 0xAA, m_ch_o = 0, stable for 3 cycles. Then raise m_ready_i: one pop, and s_credit_o[0] pulses once, the cycle after the pop.
- Fill ch0 with 0x11 and 0x12 and ch1 with 0x21 and 0x22, then hold m_ready_i = 1: output order 0x11, 0x21, 0x12, 0x22. Exactly 2 credit pulses per channel.
- Write 5 beats to ch1 with m_ready_i = 0: the 5th beat (0xEE) never appears on the output, and ch0 traffic is unaffected. With VC_VR_MC_ERR_EN, err_o = 1 the cycle after the 5th beat and stays high.
- With ch0 holding 1 entry, write 0xBB to ch0 in the same cycle it pops: occupancy stays 1, 0xBB is next out, and 1 credit is returned.
- With 3 entries buffered, pulse rst_n low between edges: m_valid_o = 0 immediately. After release, 4 fresh credits per channel and no stale data appears.

Source files
------------

// File: rtl/vc_vr_mc_pkg.sv
// Shared types and width helpers for the multi-channel valid/credit to valid/ready converter.
// No logic; no latency; no backpressure.
package vc_vr_mc_pkg;

    localparam int CH_IDX_W       = 8;
    localparam int DEF_CREDIT_NUM = 4;

    // Wide channel index for internal arbitration arithmetic; truncated at the ports.
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    function automatic int ch_width(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    function automatic int cnt_width(input int credit_num);
        return $clog2(credit_num + 1);
    endfunction

endpackage

// File: rtl/vc_vr_ch_fifo.sv
// One virtual channel: circular buffer, occupancy, pending-credit counter with registered credit.
// Head visible one cycle after write; credit pulse starts the cycle after a pop.
// Backpressure: caller must not write when full or read when empty.
module vc_vr_ch_fifo
    import vc_vr_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = DEF_CREDIT_NUM,
    localparam int CNT_WIDTH = cnt_width(CREDIT_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full,
    output logic                  credit
);

    localparam int PTR_W = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(CREDIT_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CREDIT_NUM);

    logic [DATA_WIDTH-1:0] mem [CREDIT_NUM];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  occ;
    logic [CNT_WIDTH-1:0]  pend;
    logic [CNT_WIDTH-1:0]  pend_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (occ == '0);
    assign full      = (occ == CNT_FULL);
    assign head_data = mem[rd_ptr];
    assign pend_nxt  = pend + CNT_WIDTH'(rd_en) - CNT_WIDTH'(credit);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pending starts at CREDIT_NUM so the initial grant falls out of the same counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            pend   <= CNT_FULL;
            credit <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ    <= occ + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
            pend   <= pend_nxt;
            credit <= (pend_nxt != '0);
        end
    end

endmodule

// File: rtl/vc_vr_mc_converter.sv
// Multi-channel valid/credit to valid/ready converter, round-robin over non-empty channels (VC_VR_MC_ERR_EN adds err_o).
// Latency: one cycle from accepted beat to m_* when its channel is granted.
// Backpressure: grant held while m_valid_o && !m_ready_i; upstream throttled purely by per-channel credits.
module vc_vr_mc_converter
    import vc_vr_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = DEF_CREDIT_NUM,
    parameter int CH_NUM     = 2,
    localparam int CH_WIDTH  = ch_width(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    input  logic [CH_WIDTH-1:0]   s_ch_i,
    output logic [CH_NUM-1:0]     s_credit_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [CH_WIDTH-1:0]   m_ch_o,
    output logic                  m_valid_o,
`ifdef VC_VR_MC_ERR_EN
    output logic                  err_o,
`endif
    input  logic                  m_ready_i
);

    logic [CH_NUM-1:0]     wr_en;
    logic [CH_NUM-1:0]     rd_en;
    logic [CH_NUM-1:0]     ch_empty;
    logic [CH_NUM-1:0]     ch_full;
    logic [DATA_WIDTH-1:0] head_data [CH_NUM];
    ch_idx_t               rr_ptr;
    ch_idx_t               rr_gnt;
    ch_idx_t               gnt;
    ch_idx_t               gnt_q;
    logic                  locked_q;
    logic                  found;
    logic                  pop;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        // Out-of-range s_ch_i matches no channel, so such beats are dropped here.
        assign wr_en[c] = s_valid_i && (s_ch_i == CH_WIDTH'(c)) && !ch_full[c];
        assign rd_en[c] = pop && (gnt == ch_idx_t'(c));

        vc_vr_ch_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .CREDIT_NUM (CREDIT_NUM)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_en[c]),
            .wr_data   (s_data_i),
            .rd_en     (rd_en[c]),
            .head_data (head_data[c]),
            .empty     (ch_empty[c]),
            .full      (ch_full[c]),
            .credit    (s_credit_o[c])
        );
    end

    always_comb begin
        rr_gnt = '0;
        found  = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (!found && !ch_empty[c] && (c == (int'(rr_ptr) + i) % CH_NUM)) begin
                    rr_gnt = ch_idx_t'(c);
                    found  = 1'b1;
                end
            end
        end
    end

    assign gnt       = locked_q ? gnt_q : rr_gnt;
    assign m_valid_o = |(~ch_empty);
    assign pop       = m_valid_o && m_ready_i;

    always_comb begin
        m_data_o = '0;
        m_ch_o   = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (m_valid_o && (gnt == ch_idx_t'(c))) begin
                m_data_o = head_data[c];
                m_ch_o   = CH_WIDTH'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            gnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            locked_q <= m_valid_o && !m_ready_i;
            gnt_q    <= gnt;
            if (pop) begin
                rr_ptr <= ch_idx_t'((int'(gnt) + 1) % CH_NUM);
            end
        end
    end

`ifdef VC_VR_MC_ERR_EN
    logic drop;
    assign drop = s_valid_i && !(|wr_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (drop) begin
            err_o <= 1'b1;
        end
    end

    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n) !drop)
        else $error("vc_vr_mc_converter: beat dropped (overflow or illegal channel)");
`endif

endmodule
